// File: rtl/register_file_param_pkg.sv
// Shared types and byte-merge helper for the parametrised register file.
// merge_bytes works on a maximum-width word; callers zero-extend and size-cast.
package register_file_param_pkg;

    typedef enum logic {
        REGFILE_CLEAR,
        REGFILE_IDLE
    } regfile_state_t;

    localparam int unsigned REGFILE_MAX_WIDTH = 256;
    localparam int unsigned REGFILE_MAX_BYTES = REGFILE_MAX_WIDTH / 8;

    typedef logic [REGFILE_MAX_WIDTH-1:0] regfile_word_t;
    typedef logic [REGFILE_MAX_BYTES-1:0] regfile_strobe_t;

    // Strobed bytes come from new_word, all other bytes keep old_word.
    function automatic regfile_word_t merge_bytes(
        input regfile_word_t   old_word,
        input regfile_word_t   new_word,
        input regfile_strobe_t strobe
    );
        regfile_word_t merged;
        merged = old_word;
        for (int unsigned i = 0; i < REGFILE_MAX_BYTES; i++) begin
            if (strobe[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: selects zero, forwarded write data or array data,
// and presents it one cycle after the index is sampled.
module regfile_read_port
    import register_file_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned ZERO_REG   = 0,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic [ADDR_WIDTH-1:0]   index_i,
    input  logic [DATA_WIDTH-1:0]   array_data_i,
    input  logic                    snoop_enable_i,
    input  logic [ADDR_WIDTH-1:0]   snoop_index_i,
    input  logic [DATA_WIDTH/8-1:0] snoop_strobe_i,
    input  logic [DATA_WIDTH-1:0]   snoop_data_i,
    output logic [DATA_WIDTH-1:0]   data_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] forwarded;

    assign forwarded = DATA_WIDTH'(merge_bytes(regfile_word_t'(array_data_i),
                                               regfile_word_t'(snoop_data_i),
                                               regfile_strobe_t'(snoop_strobe_i)));

    always_comb begin
        data_d = array_data_i;
        if ((ZERO_REG != 0) && (index_i == '0)) begin
            data_d = '0;
        end else if ((BYPASS != 0) && snoop_enable_i && (snoop_index_i == index_i)) begin
            data_d = forwarded;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/register_file_param.sv
// Parametrised two-read/one-write register file with byte strobes, optional
// bypass and hardwired zero, cleared one entry per cycle after reset or request.
module register_file_param
    import register_file_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned ZERO_REG   = 0,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   read_index_a,
    output logic [DATA_WIDTH-1:0]   read_data_a,
    input  logic [ADDR_WIDTH-1:0]   read_index_b,
    output logic [DATA_WIDTH-1:0]   read_data_b,
    input  logic [ADDR_WIDTH-1:0]   write_index,
    input  logic                    write_enable,
    input  logic [DATA_WIDTH/8-1:0] write_strobe,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    clear_request,
    output logic                    busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0) || (DATA_WIDTH > REGFILE_MAX_WIDTH)) begin : g_bad_width
        $error("register_file_param: DATA_WIDTH must be a non-zero multiple of 8, at most 256");
    end

    regfile_state_t        state_q;
    regfile_state_t        state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q;
    logic [ADDR_WIDTH-1:0] clr_idx_d;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    logic                  clearing;
    logic                  wr_commit;
    logic [DATA_WIDTH-1:0] wr_merged;

    assign clearing = (state_q == REGFILE_CLEAR);
    assign busy     = clearing;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= REGFILE_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            REGFILE_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == '1) begin
                    state_d = REGFILE_IDLE;
                end
            end
            REGFILE_IDLE: begin
                if (clear_request) begin
                    state_d   = REGFILE_CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = REGFILE_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // Writes to entry 0 are discarded when it is hardwired to zero.
    assign wr_commit = !clearing && write_enable
                       && ((write_index != '0) || (ZERO_REG == 0));

    assign wr_merged = DATA_WIDTH'(merge_bytes(regfile_word_t'(regs_q[write_index]),
                                               regfile_word_t'(write_data),
                                               regfile_strobe_t'(write_strobe)));

    // The array itself carries no reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clearing) begin
                regs_q[clr_idx_q] <= '0;
            end else if (wr_commit) begin
                regs_q[write_index] <= wr_merged;
            end
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_port_a (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (clearing),
        .index_i        (read_index_a),
        .array_data_i   (regs_q[read_index_a]),
        .snoop_enable_i (write_enable),
        .snoop_index_i  (write_index),
        .snoop_strobe_i (write_strobe),
        .snoop_data_i   (write_data),
        .data_o         (read_data_a)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_port_b (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (clearing),
        .index_i        (read_index_b),
        .array_data_i   (regs_q[read_index_b]),
        .snoop_enable_i (write_enable),
        .snoop_index_i  (write_index),
        .snoop_strobe_i (write_strobe),
        .snoop_data_i   (write_data),
        .data_o         (read_data_b)
    );

endmodule
